mult4b_seq: RTL and testbench



---
 rtl/mult4b_seq_pkg.sv | 24 ++
 rtl/mult4b_seq_adder4b.sv | 26 ++
 rtl/mult4b_seq.sv | 125 ++++++++++++
 tb/tb_mult4b_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult4b_seq_pkg.sv
// Shared definitions for the mult4b_seq multiplier: operand/product widths,
// iteration counter width and the controller state encoding.
package mult4b_seq_pkg;

    // Operand width is tied to the width of the shared adder.
    localparam int N_BITS = 4;

    // Iteration counter width, log2(N_BITS).
    localparam int CNT_W = 2;

    // Full product width.
    localparam int PROD_W = 2 * N_BITS;

    // Counter value on the final shift-and-add iteration.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

    // Controller states; 2'b11 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult4b_seq_adder4b.sv
// adder4b: plain 4-bit ripple-carry adder shared by every iteration of
// the mult4b_seq shift-and-add loop.
module adder4b
    import mult4b_seq_pkg::*;
(
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic              cin,
    output logic [N_BITS-1:0] sum,
    output logic              cout
);

    logic carry;

    // Ripple the carry from bit 0 upward, one full adder per bit.
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < N_BITS; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/mult4b_seq.sv
// mult4b_seq: sequential 4x4 unsigned shift-and-add multiplier.
// One partial product per clock through a single shared adder4b, with a
// start/busy/done handshake and a registered 8-bit product.
// Optional build macro MULT_ZERO_BYPASS_EN: when defined, a start with a
// zero operand skips the iterations and goes straight to DONE with a zero
// product.
module mult4b_seq
    import mult4b_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_t            state;
    state_t            state_next;
    logic [N_BITS-1:0] a_r;
    logic [N_BITS-1:0] h;
    logic [N_BITS-1:0] l;
    logic [CNT_W-1:0]  cnt;
    logic [N_BITS-1:0] addend;
    logic [N_BITS-1:0] sum;
    logic              carry;
    logic [N_BITS-1:0] h_next;
    logic [N_BITS-1:0] l_next;
    logic              zero_operands;

    // The multiplicand is added only when the current multiplier bit is set.
    assign addend = l[0] ? a_r : '0;

    adder4b u_adder (
        .a    (h),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // {carry, sum, L} shifts right by one: carry enters H, sum LSB enters L.
    assign h_next = {carry, sum[N_BITS-1:1]};
    assign l_next = {sum[0], l[N_BITS-1:1]};

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_operands = (a == '0) || (b == '0);
`else
    assign zero_operands = 1'b0;
`endif

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; the illegal encoding falls back to IDLE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = zero_operands ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and product load.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            h       <= '0;
            l       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r <= a;
                        l   <= b;
                        h   <= '0;
                        cnt <= '0;
                        if (zero_operands) begin
                            product <= '0;
                        end
                    end
                end
                S_CALC: begin
                    h   <= h_next;
                    l   <= l_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        product <= {h_next, l_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult4b_seq.sv
// Self-checking bench for mult4b_seq: a table of known products, randomized
// operations against an arithmetic reference, and hand-written sequences for
// start-while-busy, reset mid-operation and back-to-back issue.
module tb_mult4b_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] expected;
    } vector_t;

    vector_t vectors[8];

    mult4b_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: edges from start acceptance until done is visible.
    function automatic int expectedLatency(input logic [3:0] av, input logic [3:0] bv);
`ifdef MULT_ZERO_BYPASS_EN
        if (av == 4'd0 || bv == 4'd0) return 1;
`endif
        if (av == 4'd15 && bv == 4'd15) return 5;
        return 5;
    endfunction

    // Reference: number of sampled cycles with busy high.
    function automatic int expectedBusyCycles(input logic [3:0] av, input logic [3:0] bv);
`ifdef MULT_ZERO_BYPASS_EN
        if (av == 4'd0 || bv == 4'd0) return 0;
`endif
        if (av == 4'd15 && bv == 4'd15) return 4;
        return 4;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Issue one operation from IDLE and watch for done; called at posedge+1.
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv,
                                 output int done_edge, output logic [7:0] prod,
                                 output int busy_cycles);
        done_edge   = 0;
        busy_cycles = 0;
        prod        = 8'd0;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        for (int k = 1; k <= 12; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_edge = k;
                prod      = product;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic runOperation(input string name, input logic [3:0] av,
                                input logic [3:0] bv, input int exp_product);
        int         lat;
        int         busy_n;
        logic [7:0] prod;
        applyStimulus(av, bv, lat, prod, busy_n);
        checkOutput({name, " product"}, int'(prod), exp_product);
        checkOutput({name, " latency"}, lat, expectedLatency(av, bv));
        checkOutput({name, " busy cycles"}, busy_n, expectedBusyCycles(av, bv));
        @(posedge clk); #1;
        checkOutput({name, " done pulse width"}, int'(done), 0);
        checkOutput({name, " product hold"}, int'(product), exp_product);
    endtask

    initial begin
        int         pulses;
        int         first_edge;
        int         busy_seen;
        int         done_edges[2];
        int         done_prods[2];
        logic [7:0] prod;
        logic [3:0] ra;
        logic [3:0] rb;

        vectors[0] = '{a: 4'd13, b: 4'd11, expected: 8'h8F};
        vectors[1] = '{a: 4'd15, b: 4'd15, expected: 8'hE1};
        vectors[2] = '{a: 4'd0,  b: 4'd9,  expected: 8'h00};
        vectors[3] = '{a: 4'd9,  b: 4'd0,  expected: 8'h00};
        vectors[4] = '{a: 4'd1,  b: 4'd1,  expected: 8'h01};
        vectors[5] = '{a: 4'd8,  b: 4'd2,  expected: 8'h10};
        vectors[6] = '{a: 4'd15, b: 4'd1,  expected: 8'h0F};
        vectors[7] = '{a: 4'd7,  b: 4'd12, expected: 8'h54};

        rst   = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset product", int'(product), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            runOperation($sformatf("vec%0d", i), vectors[i].a, vectors[i].b,
                         int'(vectors[i].expected));
        end

        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            runOperation($sformatf("rand%0d", i), ra, rb, int'(ra) * int'(rb));
        end

        // Start pulse during CALC must be ignored.
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd5;
        @(posedge clk); #1;
        start      = 1'b0;
        a          = 4'd0;
        b          = 4'd0;
        pulses     = 0;
        first_edge = 0;
        prod       = 8'd0;
        for (int k = 1; k <= 12; k++) begin
            if (done) begin
                pulses++;
                if (first_edge == 0) begin
                    first_edge = k;
                    prod       = product;
                end
            end
            if (k == 2) begin
                start = 1'b1;
                a     = 4'd7;
                b     = 4'd7;
            end
            if (k == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("busy-start done count", pulses, 1);
        checkOutput("busy-start latency", first_edge, 5);
        checkOutput("busy-start product", int'(prod), 15);

        // Reset on the third CALC edge discards the operation.
        runOperation("pre-reset", 4'd13, 4'd11, 143);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid-reset busy", int'(busy), 0);
        checkOutput("mid-reset done", int'(done), 0);
        checkOutput("mid-reset product", int'(product), 0);
        pulses    = 0;
        busy_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (busy) busy_seen++;
        end
        checkOutput("post-reset idle done", pulses, 0);
        checkOutput("post-reset idle busy", busy_seen, 0);
        runOperation("after-reset", 4'd2, 4'd3, 6);

        // Start held high across two operations.
        start = 1'b1;
        a     = 4'd6;
        b     = 4'd7;
        @(posedge clk); #1;
        a             = 4'd5;
        b             = 4'd4;
        pulses        = 0;
        done_edges[0] = 0;
        done_edges[1] = 0;
        done_prods[0] = 0;
        done_prods[1] = 0;
        for (int k = 1; k <= 16; k++) begin
            if (done) begin
                if (pulses < 2) begin
                    done_edges[pulses] = k;
                    done_prods[pulses] = int'(product);
                end
                pulses++;
            end
            if (k == 7) start = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("b2b done count", pulses, 2);
        checkOutput("b2b first edge", done_edges[0], 5);
        checkOutput("b2b second edge", done_edges[1], 5 + 6);
        checkOutput("b2b first product", done_prods[0], 6 * 7);
        checkOutput("b2b second product", done_prods[1], 5 * 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
